stopwatch_ctrl: RTL and testbench

- Sequencing controller for the free-running 27-bit prescaler counter (100 MHz → 1 Hz; `cnt_max` high when count = 99_999_999).
- Turns start/stop and clear button pulses into the counter's `en`/`clr` controls.
- Accumulates qualified 1 s ticks into seconds/minutes.
- Presents display time to the 7-segment/LED layer above.

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/time_accum.sv | 47 ++++
 rtl/stopwatch_ctrl.sv | 113 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller and its time accumulator.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_e;

    localparam int unsigned SEC_W       = 6;
    localparam int unsigned MIN_W       = 7;
    localparam int unsigned SEC_MAX_DEF = 59;
    localparam int unsigned MIN_MAX_DEF = 99;

endpackage : stopwatch_pkg

// File: rtl/time_accum.sv
// Chained seconds/minutes counters advanced by one qualified 1 s tick per inc pulse.
module time_accum
    import stopwatch_pkg::*;
#(
    parameter int unsigned SEC_MAX = SEC_MAX_DEF,
    parameter int unsigned MIN_MAX = MIN_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [SEC_W-1:0] sec,
    output logic [MIN_W-1:0] min,
    output logic             wrap
);

    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_MAX);
    localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MIN_MAX);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sec  <= '0;
            min  <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clr) begin
                sec <= '0;
                min <= '0;
            end else if (inc) begin
                if (sec != SEC_LAST) begin
                    sec <= sec + 1'b1;
                end else begin
                    sec <= '0;
                    if (min != MIN_LAST) begin
                        min <= min + 1'b1;
                    end else begin
                        min  <= '0;
                        wrap <= 1'b1;
                    end
                end
            end
        end
    end

endmodule : time_accum

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/clear sequencer with display registers.
// Lap freeze is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned SEC_MAX = SEC_MAX_DEF,
    parameter int unsigned MIN_MAX = MIN_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_stop,
    input  logic             clear,
    input  logic             lap,
    input  logic             tick,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic [SEC_W-1:0] sec,
    output logic [MIN_W-1:0] min,
    output logic [SEC_W-1:0] disp_sec,
    output logic [MIN_W-1:0] disp_min,
    output logic             running,
    output logic             wrap,
    output logic             lap_active
);

    sw_state_e state, next_state;
    logic      clr_accept;
    logic      lap_next;

    time_accum #(
        .SEC_MAX (SEC_MAX),
        .MIN_MAX (MIN_MAX)
    ) u_time_accum (
        .clk  (clk),
        .rst  (rst),
        .inc  (tick & cnt_en),
        .clr  (clr_accept),
        .sec  (sec),
        .min  (min),
        .wrap (wrap)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        clr_accept = 1'b0;
        unique case (state)
            IDLE: begin
                if (clear) begin
                    clr_accept = 1'b1;
                end else if (start_stop) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (start_stop) begin
                    next_state = PAUSE;
                end
            end
            PAUSE: begin
                if (clear) begin
                    clr_accept = 1'b1;
                    next_state = IDLE;
                end else if (start_stop) begin
                    next_state = RUN;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The prescaler must count in the very cycle RUN is entered, so this is a pure state decode.
    always_comb begin
        cnt_en = (state == RUN);
    end

`ifdef STOPWATCH_LAP_EN
    always_comb begin
        lap_next = lap_active;
        if (next_state == IDLE) begin
            lap_next = 1'b0;
        end else if (state == RUN && lap) begin
            lap_next = ~lap_active;
        end
    end
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign lap_next   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            running    <= 1'b0;
            cnt_clr    <= 1'b0;
            lap_active <= 1'b0;
            disp_sec   <= '0;
            disp_min   <= '0;
        end else begin
            state      <= next_state;
            running    <= (next_state == RUN);
            cnt_clr    <= clr_accept;
            lap_active <= lap_next;
            // Hold only while the freeze persists; setting or releasing it reloads live time.
            if (!(lap_active && lap_next)) begin
                disp_sec <= sec;
                disp_min <= min;
            end
        end
    end

endmodule : stopwatch_ctrl

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl using an expectation queue.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_stop = 1'b0;
    logic             clear = 1'b0;
    logic             lap = 1'b0;
    logic             tick = 1'b0;
    logic             cnt_en, cnt_clr, running, wrap, lap_active;
    logic [SEC_W-1:0] sec, disp_sec;
    logic [MIN_W-1:0] min, disp_min;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef enum int {S_SEC, S_MIN, S_DSEC, S_DMIN, S_RUN, S_EN, S_CLR, S_WRAP, S_LAP} sig_e;
    typedef struct {
        string       tag;
        sig_e        sig;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    stopwatch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .tick       (tick),
        .cnt_en     (cnt_en),
        .cnt_clr    (cnt_clr),
        .sec        (sec),
        .min        (min),
        .disp_sec   (disp_sec),
        .disp_min   (disp_min),
        .running    (running),
        .wrap       (wrap),
        .lap_active (lap_active)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] observe(sig_e s);
        case (s)
            S_SEC:   return 32'(sec);
            S_MIN:   return 32'(min);
            S_DSEC:  return 32'(disp_sec);
            S_DMIN:  return 32'(disp_min);
            S_RUN:   return 32'(running);
            S_EN:    return 32'(cnt_en);
            S_CLR:   return 32'(cnt_clr);
            S_WRAP:  return 32'(wrap);
            default: return 32'(lap_active);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input sig_e s, input int v);
        exp_t e;
        e.tag = tag;
        e.sig = s;
        e.exp = 32'(v);
        sb.push_back(e);
    endtask

    task automatic push_time(input string tag, input int m, input int s);
        push({tag, "_min"}, S_MIN, m);
        push({tag, "_sec"}, S_SEC, s);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sig), e.exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; return 1 time unit after the rising edge.
    task automatic cyc(input logic ss, input logic cl, input logic lp, input logic tk);
        @(negedge clk);
        rst        = 1'b0;
        start_stop = ss;
        clear      = cl;
        lap        = lp;
        tick       = tk;
        @(posedge clk);
        #1;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
        tick       = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic push_zero(input string tag);
        push_time(tag, 0, 0);
        push({tag, "_dsec"}, S_DSEC, 0);
        push({tag, "_dmin"}, S_DMIN, 0);
        push({tag, "_run"},  S_RUN,  0);
        push({tag, "_en"},   S_EN,   0);
        push({tag, "_clr"},  S_CLR,  0);
        push({tag, "_wrap"}, S_WRAP, 0);
        push({tag, "_lap"},  S_LAP,  0);
    endtask

    initial begin
        // Reset state
        push_zero("reset");
        do_reset();
        do_reset();
        drain();

        // Start, three ticks
        push("start_run", S_RUN, 1);
        push("start_en", S_EN, 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        drain();
        run_ticks(2);
        push_time("tick3", 0, 3);
        push("tick3_dsec_lag", S_DSEC, 2);
        run_ticks(1);
        drain();
        push("disp_track", S_DSEC, 3);
        cyc(1'b0, 1'b0, 1'b0, 0);
        drain();

        // Pause with tick held high must not advance
        push("pause_run", S_RUN, 0);
        push("pause_en", S_EN, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        drain();
        run_ticks(10);
        push_time("pause_hold", 0, 3);
        push("pause_hold_en", S_EN, 0);
        drain();
        push("resume_en", S_EN, 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        drain();
        push_time("resume_tick", 0, 4);
        run_ticks(1);
        drain();

        // Seconds rollover and full wrap
        run_ticks(55);
        push_time("pre_min", 0, 59);
        drain();
        push_time("sec_roll", 1, 0);
        run_ticks(1);
        drain();
        run_ticks(5939);
        push_time("pre_wrap", 99, 59);
        push("pre_wrap_flag", S_WRAP, 0);
        drain();
        push_time("wrap", 0, 0);
        push("wrap_pulse", S_WRAP, 1);
        run_ticks(1);
        drain();
        push("wrap_one_cycle", S_WRAP, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        // Clear with start_stop in RUN pauses and keeps time
        run_ticks(5);
        push_time("ss_clr_run", 0, 5);
        push("ss_clr_run_state", S_RUN, 0);
        push("ss_clr_run_cclr", S_CLR, 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        drain();
        push_time("pause_clear", 0, 0);
        push("pause_clear_cclr", S_CLR, 1);
        push("pause_clear_run", S_RUN, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        drain();
        push("cclr_one_cycle", S_CLR, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        // IDLE: clear wins over start_stop
        push("idle_both_run", S_RUN, 0);
        push("idle_both_cclr", S_CLR, 1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        drain();
        push("idle_both_stay", S_EN, 0);
        push("idle_both_cclr_end", S_CLR, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        drain();

        // Reset mid-RUN at 12:34
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        run_ticks(754);
        push_time("at_1234", 12, 34);
        drain();
        push("disp_1234_min", S_DMIN, 12);
        push("disp_1234_sec", S_DSEC, 34);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        drain();
        push_zero("rst_run");
        do_reset();
        drain();
        push_time("idle_tick_ignored", 0, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        drain();

        // Lap behaviour
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        run_ticks(5);
`ifdef STOPWATCH_LAP_EN
        push("lap_set", S_LAP, 1);
        push("lap_set_dsec", S_DSEC, 5);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        drain();
        push_time("lap_live", 0, 8);
        push("lap_hold_dsec", S_DSEC, 5);
        push("lap_hold_flag", S_LAP, 1);
        run_ticks(3);
        drain();
        push("lap_release", S_LAP, 0);
        push("lap_release_dsec", S_DSEC, 8);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        drain();
`else
        push("lap_ignored", S_LAP, 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        drain();
        push_time("lap_live", 0, 8);
        push("lap_track_dsec", S_DSEC, 7);
        push("lap_ignored_flag", S_LAP, 0);
        run_ticks(3);
        drain();
        push("lap_track_final", S_DSEC, 8);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_stopwatch_ctrl
